// File: rtl/player_pose_controller.sv
`default_nettype none
// ============================================================================
// player_pose_controller : per-video-frame player pose, animation, lives and
//                          invulnerability sequencer driving the sprite fetch
// Rev 1.0
// ============================================================================
module player_pose_controller #(
  parameter int FRAME_WORDS     = 3024,
  parameter int STAND_BASE      = 0,
  parameter int RUN_BASE        = 3024,
  parameter int AIMUP_BASE      = 12096,
  parameter int RUNUP_BASE      = 15120,
  parameter int PRONE_BASE      = 24192,
  parameter int JUMP_BASE       = 27216,
  parameter int DEATH_BASE      = 39312,
  parameter int LEFT_OFFSET     = 48384,
  parameter int TICKS_PER_FRAME = 4,
  parameter int JUMP_MIN        = 8,
  parameter int DEATH_TICKS     = 32,
  parameter int INVULN_TICKS    = 120,
  parameter int LIVES           = 3
) (
  input  logic        frame_Clk,
  input  logic        Reset,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic        jumpBtn,
  input  logic        onGround,
  input  logic        hit,
  output logic [20:0] spriteBase,
  output logic [2:0]  pose,
  output logic        playerDirection,
  output logic        moving,
  output logic        visible,
  output logic [1:0]  livesLeft
);

  typedef enum logic [2:0] {
    POSE_STAND    = 3'd0,
    POSE_RUN      = 3'd1,
    POSE_AIM_UP   = 3'd2,
    POSE_RUN_UP   = 3'd3,
    POSE_PRONE    = 3'd4,
    POSE_JUMP     = 3'd5,
    POSE_DYING    = 3'd6,
    POSE_GAMEOVER = 3'd7
  } pose_t;

  localparam logic [20:0] c_frame_words = 21'(FRAME_WORDS);
  localparam logic [20:0] c_left_offset = 21'(LEFT_OFFSET);
  localparam logic [1:0]  c_tick_last   = 2'(TICKS_PER_FRAME - 1);
  localparam logic [7:0]  c_jump_last   = 8'(JUMP_MIN - 1);
  localparam logic [7:0]  c_death_last  = 8'(DEATH_TICKS - 1);
  localparam logic [7:0]  c_invuln      = 8'(INVULN_TICKS);
  localparam logic [1:0]  c_lives       = 2'(LIVES);

  pose_t       pose_q, pose_d;
  logic        dir_q, dir_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  invuln_q, invuln_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  tick_q, tick_d;
  logic [1:0]  frame_q, frame_d;
  logic        jump_prev_q;
  logic        horiz;
  logic [20:0] base_sel;
  logic [1:0]  sheet_frame;

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      pose_q      <= POSE_STAND;
      dir_q       <= 1'b0;
      lives_q     <= c_lives;
      invuln_q    <= 8'd0;
      timer_q     <= 8'd0;
      tick_q      <= 2'd0;
      frame_q     <= 2'd0;
      jump_prev_q <= 1'b0;
    end else begin
      pose_q      <= pose_d;
      dir_q       <= dir_d;
      lives_q     <= lives_d;
      invuln_q    <= invuln_d;
      timer_q     <= timer_d;
      tick_q      <= tick_d;
      frame_q     <= frame_d;
      jump_prev_q <= jumpBtn;
    end
  end

  always_comb begin
    horiz    = left ^ right;
    pose_d   = pose_q;
    lives_d  = lives_q;
    invuln_d = (invuln_q != 8'd0) ? invuln_q - 8'd1 : 8'd0;
    dir_d    = dir_q;

    if (pose_q == POSE_GAMEOVER) begin
      pose_d = POSE_GAMEOVER;
    end else if (hit && invuln_q == 8'd0 && pose_q != POSE_DYING) begin
      pose_d = POSE_DYING;
    end else if (pose_q == POSE_DYING) begin
      if (timer_q == c_death_last) begin
        if (lives_q == 2'd0) begin
          pose_d = POSE_GAMEOVER;
        end else begin
          lives_d  = lives_q - 2'd1;
          pose_d   = POSE_STAND;
          invuln_d = c_invuln;
        end
      end
    end else if (pose_q == POSE_JUMP) begin
      // Landing only returns to STAND; ground rules apply on the next edge.
      if (onGround && timer_q >= c_jump_last) pose_d = POSE_STAND;
    end else if (pose_q != POSE_PRONE && jumpBtn && !jump_prev_q && onGround) begin
      pose_d = POSE_JUMP;
    end else if (down && onGround) begin
      pose_d = POSE_PRONE;
    end else if (up && horiz) begin
      pose_d = POSE_RUN_UP;
    end else if (up) begin
      pose_d = POSE_AIM_UP;
    end else if (horiz) begin
      pose_d = POSE_RUN;
    end else begin
      pose_d = POSE_STAND;
    end

    if (horiz && pose_q != POSE_DYING && pose_q != POSE_GAMEOVER) dir_d = left;

    // One shared timer serves both the jump and death durations.
    if (pose_d != pose_q) begin
      timer_d = 8'd0;
      tick_d  = 2'd0;
      frame_d = 2'd0;
    end else begin
      timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
      tick_d  = (tick_q == c_tick_last) ? 2'd0 : tick_q + 2'd1;
      frame_d = frame_q;
      if (tick_q == c_tick_last) begin
        case (pose_q)
          POSE_RUN, POSE_RUN_UP, POSE_JUMP: frame_d = frame_q + 2'd1;
          POSE_DYING:                       frame_d = (frame_q == 2'd2) ? 2'd2 : frame_q + 2'd1;
          default:                          frame_d = 2'd0;
        endcase
      end
    end
  end

  always_comb begin
    base_sel    = 21'(STAND_BASE);
    sheet_frame = 2'd0;
    case (pose_q)
      POSE_STAND:  base_sel = 21'(STAND_BASE);
      POSE_RUN: begin
        base_sel    = 21'(RUN_BASE);
        sheet_frame = (frame_q == 2'd3) ? 2'd1 : frame_q;
      end
      POSE_AIM_UP: base_sel = 21'(AIMUP_BASE);
      POSE_RUN_UP: begin
        base_sel    = 21'(RUNUP_BASE);
        sheet_frame = (frame_q == 2'd3) ? 2'd1 : frame_q;
      end
      POSE_PRONE:  base_sel = 21'(PRONE_BASE);
      POSE_JUMP: begin
        base_sel    = 21'(JUMP_BASE);
        sheet_frame = frame_q;
      end
      POSE_DYING: begin
        base_sel    = 21'(DEATH_BASE);
        sheet_frame = frame_q;
      end
      default: begin
        base_sel    = 21'(DEATH_BASE);
        sheet_frame = 2'd2;
      end
    endcase
  end

  assign spriteBase      = base_sel + 21'(sheet_frame) * c_frame_words
                         + (dir_q ? c_left_offset : 21'd0);
  assign pose            = pose_q;
  assign playerDirection = dir_q;
  assign moving          = (pose_q == POSE_RUN) || (pose_q == POSE_RUN_UP);
  assign visible         = (pose_q != POSE_GAMEOVER) && ((invuln_q == 8'd0) || !invuln_q[2]);
  assign livesLeft       = lives_q;

endmodule
`default_nettype wire

// File: tb/tb_player_pose_controller.sv
`default_nettype none
// ============================================================================
// tb_player_pose_controller : directed self-checking bench
// Rev 1.0
// ============================================================================
module tb_player_pose_controller;

  logic        frame_Clk = 1'b0;
  logic        Reset, left, right, up, down, jumpBtn, onGround, hit;
  logic [20:0] spriteBase;
  logic [2:0]  pose;
  logic        playerDirection, moving, visible;
  logic [1:0]  livesLeft;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 frame_Clk = ~frame_Clk;

  player_pose_controller dut (
    .frame_Clk       (frame_Clk),
    .Reset           (Reset),
    .left            (left),
    .right           (right),
    .up              (up),
    .down            (down),
    .jumpBtn         (jumpBtn),
    .onGround        (onGround),
    .hit             (hit),
    .spriteBase      (spriteBase),
    .pose            (pose),
    .playerDirection (playerDirection),
    .moving          (moving),
    .visible         (visible),
    .livesLeft       (livesLeft)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic lose_life(input logic [1:0] exp_lives);
    hit = 1'b1; step(1); hit = 1'b0;
    chk("die_pose", 32'(pose), 32'd6);
    step(31);
    chk("die_hold", 32'(pose), 32'd6);
    step(1);
    chk("respawn_pose", 32'(pose), 32'd0);
    chk("respawn_lives", 32'(livesLeft), 32'(exp_lives));
    step(120);
  endtask

  initial begin
    Reset = 1'b1; left = 0; right = 0; up = 0; down = 0; jumpBtn = 0; onGround = 1; hit = 0;
    step(1);
    Reset = 1'b0;
    chk("rst_pose", 32'(pose), 32'd0);
    chk("rst_base", 32'(spriteBase), 32'd0);
    chk("rst_lives", 32'(livesLeft), 32'd3);
    chk("rst_visible", 32'(visible), 32'd1);
    chk("rst_dir", 32'(playerDirection), 32'd0);
    chk("rst_moving", 32'(moving), 32'd0);
    step(5);
    chk("idle_pose", 32'(pose), 32'd0);
    chk("idle_base", 32'(spriteBase), 32'd0);

    // Run right: 0,1,2,1,0 sheet frames, four edges each
    right = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step(1);
      chk("run_base", 32'(spriteBase),
          (k < 4) ? 32'd3024 : (k < 8) ? 32'd6048 : (k < 12) ? 32'd9072 : (k < 16) ? 32'd6048 : 32'd3024);
    end
    chk("run_moving", 32'(moving), 32'd1);
    right = 1'b0; left = 1'b1;
    step(1);
    chk("turn_dir", 32'(playerDirection), 32'd1);
    chk("turn_base", 32'(spriteBase), 32'd51408);
    step(2);
    chk("turn_hold", 32'(spriteBase), 32'd51408);
    step(1);
    chk("turn_adv", 32'(spriteBase), 32'd54432);

    // Jump from standing, facing right
    left = 1'b0; right = 1'b1; step(1);
    right = 1'b0; step(1);
    chk("stand_base", 32'(spriteBase), 32'd0);
    jumpBtn = 1'b1; step(1);
    chk("jump_pose", 32'(pose), 32'd5);
    chk("jump_base", 32'(spriteBase), 32'd27216);
    onGround = 1'b0; step(3);
    chk("air_pose", 32'(pose), 32'd5);
    onGround = 1'b1; step(1);
    chk("jump_frame1", 32'(spriteBase), 32'd30240);
    step(3);
    chk("jump_min_hold", 32'(pose), 32'd5);
    step(1);
    chk("land_pose", 32'(pose), 32'd0);
    step(1);
    chk("no_retrigger", 32'(pose), 32'd0);
    jumpBtn = 1'b0;
    left = 1'b1; right = 1'b1; step(1);
    chk("lr_dir", 32'(playerDirection), 32'd0);
    chk("lr_pose", 32'(pose), 32'd0);
    left = 1'b0; right = 1'b0; step(1);

    // First death and respawn blink
    hit = 1'b1; step(1); hit = 1'b0;
    chk("hit_pose", 32'(pose), 32'd6);
    chk("dying_f0", 32'(spriteBase), 32'd39312);
    step(4);
    chk("dying_f1", 32'(spriteBase), 32'd42336);
    step(4);
    chk("dying_f2", 32'(spriteBase), 32'd45360);
    step(4);
    chk("dying_f2_hold", 32'(spriteBase), 32'd45360);
    left = 1'b1; step(19);
    chk("dying_pose31", 32'(pose), 32'd6);
    chk("dying_dir", 32'(playerDirection), 32'd0);
    left = 1'b0; step(1);
    chk("respawn1_pose", 32'(pose), 32'd0);
    chk("respawn1_lives", 32'(livesLeft), 32'd2);
    chk("respawn1_vis", 32'(visible), 32'd1);
    step(1);
    chk("blink_off", 32'(visible), 32'd0);
    step(4);
    chk("blink_on", 32'(visible), 32'd1);
    hit = 1'b1; step(1); hit = 1'b0;
    chk("invuln_hit_pose", 32'(pose), 32'd0);
    chk("invuln_hit_lives", 32'(livesLeft), 32'd2);
    step(114);
    chk("invuln_done_vis", 32'(visible), 32'd1);

    // Burn remaining lives, then game over
    lose_life(2'd1);
    lose_life(2'd0);
    hit = 1'b1; jumpBtn = 1'b1; step(1); hit = 1'b0; jumpBtn = 1'b0;
    chk("hit_beats_jump", 32'(pose), 32'd6);
    step(31);
    chk("last_dying", 32'(pose), 32'd6);
    step(1);
    chk("gameover_pose", 32'(pose), 32'd7);
    chk("gameover_vis", 32'(visible), 32'd0);
    chk("gameover_base", 32'(spriteBase), 32'd45360);
    left = 1'b1; jumpBtn = 1'b1; step(3);
    chk("gameover_hold", 32'(pose), 32'd7);
    chk("gameover_dir", 32'(playerDirection), 32'd0);
    Reset = 1'b1; step(1); Reset = 1'b0;
    left = 1'b0; jumpBtn = 1'b0;
    chk("rerst_pose", 32'(pose), 32'd0);
    chk("rerst_lives", 32'(livesLeft), 32'd3);

    // Prone blocks jumping; release into run-aim-up facing left
    down = 1'b1; right = 1'b1; step(1);
    chk("prone_pose", 32'(pose), 32'd4);
    chk("prone_base", 32'(spriteBase), 32'd24192);
    chk("prone_moving", 32'(moving), 32'd0);
    jumpBtn = 1'b1; step(1);
    chk("prone_nojump", 32'(pose), 32'd4);
    jumpBtn = 1'b0; down = 1'b0; right = 1'b0; up = 1'b1; left = 1'b1; step(1);
    chk("runup_pose", 32'(pose), 32'd3);
    chk("runup_base", 32'(spriteBase), 32'd63504);
    chk("runup_moving", 32'(moving), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
